// File: rtl/match_sequencer.sv
// Match phase controller for the ball-and-paddle game: serve timing, rally scoring, win detection.
// Optional pause input enabled by defining MATCH_SEQUENCER_PAUSE_EN.
module match_sequencer #(
  parameter int unsigned WIN_SCORE          = 11,
  parameter int unsigned SERVE_DELAY_FRAMES = 60,
  parameter int unsigned GAMEOVER_FRAMES    = 180
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_p1,
  input  logic       miss_p2,
`ifdef MATCH_SEQUENCER_PAUSE_EN
  input  logic       pause,
`endif
  output logic       ball_en,
  output logic       players_en,
  output logic       ball_hold,
  output logic       serve_dir,
  output logic [5:0] score_p1,
  output logic [5:0] score_p2,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StServe = 3'd1,
    StRally = 3'd2,
    StPoint = 3'd3,
    StOver  = 3'd4
  } state_e;

  localparam int unsigned CntMax = (SERVE_DELAY_FRAMES > GAMEOVER_FRAMES) ?
                                   SERVE_DELAY_FRAMES : GAMEOVER_FRAMES;
  localparam int unsigned CntW   = $clog2(CntMax) + 1;
  localparam logic [CntW-1:0] ServeLast = CntW'(SERVE_DELAY_FRAMES - 1);
  localparam logic [CntW-1:0] OverLast  = CntW'(GAMEOVER_FRAMES - 1);
  localparam logic [5:0]      WinScore  = 6'(WIN_SCORE);
  localparam logic [5:0]      ScoreMax  = 6'd63;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [5:0]      score_p1_q, score_p1_d;
  logic [5:0]      score_p2_q, score_p2_d;
  logic            serve_dir_q, serve_dir_d;
  logic            winner_q, winner_d;
  logic            start_low_q;
  logic            start_edge;
  logic            paused_q, paused_d;

  // Edge detector is armed only once start has been seen low, so a held button never fires.
  assign start_edge = start & start_low_q;

`ifdef MATCH_SEQUENCER_PAUSE_EN
  logic pause_q;
  logic pause_edge;

  assign pause_edge = pause & ~pause_q;

  always_comb begin
    paused_d = paused_q;
    if (pause_edge && (state_q == StServe || state_q == StRally)) begin
      paused_d = ~paused_q;
    end
    if (state_d == StIdle || state_d == StOver) begin
      paused_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pause_q  <= 1'b0;
      paused_q <= 1'b0;
    end else begin
      pause_q  <= pause;
      paused_q <= paused_d;
    end
  end
`else
  assign paused_q = 1'b0;
  assign paused_d = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    score_p1_d  = score_p1_q;
    score_p2_d  = score_p2_q;
    serve_dir_d = serve_dir_q;
    winner_d    = winner_q;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          state_d     = StServe;
          cnt_d       = '0;
          score_p1_d  = '0;
          score_p2_d  = '0;
          serve_dir_d = 1'b0;
        end
      end
      StServe: begin
        if (!paused_q && frame_tick) begin
          if (cnt_q == ServeLast) begin
            state_d = StRally;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      StRally: begin
        if (!paused_q && (miss_p1 || miss_p2)) begin
          state_d = StPoint;
          // A simultaneous double miss is a void point.
          if (miss_p1 && !miss_p2) begin
            if (score_p2_q != ScoreMax) score_p2_d = score_p2_q + 6'd1;
            serve_dir_d = 1'b0;
          end else if (miss_p2 && !miss_p1) begin
            if (score_p1_q != ScoreMax) score_p1_d = score_p1_q + 6'd1;
            serve_dir_d = 1'b1;
          end
        end
      end
      StPoint: begin
        cnt_d = '0;
        if (score_p1_q >= WinScore) begin
          winner_d = 1'b0;
          state_d  = StOver;
        end else if (score_p2_q >= WinScore) begin
          winner_d = 1'b1;
          state_d  = StOver;
        end else begin
          state_d = StServe;
        end
      end
      StOver: begin
        if (start_edge) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else if (frame_tick) begin
          if (cnt_q == OverLast) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      score_p1_q  <= '0;
      score_p2_q  <= '0;
      serve_dir_q <= 1'b0;
      winner_q    <= 1'b0;
      start_low_q <= 1'b0;
      ball_en     <= 1'b0;
      players_en  <= 1'b0;
      ball_hold   <= 1'b1;
      game_over   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      score_p1_q  <= score_p1_d;
      score_p2_q  <= score_p2_d;
      serve_dir_q <= serve_dir_d;
      winner_q    <= winner_d;
      start_low_q <= ~start;
      // Outputs decode the next state so they switch together with state.
      ball_en     <= (state_d == StRally) && !paused_d;
      players_en  <= (state_d == StServe || state_d == StRally || state_d == StPoint) &&
                     !paused_d;
      ball_hold   <= (state_d != StRally);
      game_over   <= (state_d == StOver);
    end
  end

  assign state     = state_q;
  assign score_p1  = score_p1_q;
  assign score_p2  = score_p2_q;
  assign serve_dir = serve_dir_q;
  assign winner    = winner_q;

endmodule
